dmem_arbiter: RTL and testbench

- Arbitrates one shared, pipelined, multi-cycle data memory between two requesters.
  - D-side: data-cache miss and write-through traffic from the MEM stage.
  - I-side: instruction-cache miss traffic from the fetch stage.
- Sequences block-read bursts and single-word writes, and returns read words with their index.
- The pipeline stalls on its own requester while that requester's req is high and its done is low.

---
 rtl/dmem_arbiter_pkg.sv | 22 ++
 rtl/dmem_burst_ctr.sv | 49 ++++
 rtl/dmem_arbiter.sv | 155 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared types and parameter defaults for the data-memory arbiter
package dmem_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR       = 3'd1,
    RD_ISSUE = 3'd2,
    RD_DRAIN = 3'd3,
    DONE     = 3'd4
  } state_t;

  typedef enum logic {
    OWN_D = 1'b0,
    OWN_I = 1'b1
  } owner_t;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_BURST  = 8;
  localparam int DEF_LAT    = 4;

endpackage

// File: rtl/dmem_burst_ctr.sv
// rtl/dmem_burst_ctr.sv - issue and return word counters for one block-read burst
module dmem_burst_ctr #(
  parameter int BURST = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     issue_inc,
  input  logic                     ret_inc,
  output logic [$clog2(BURST)-1:0] issue_cnt,
  output logic [$clog2(BURST)-1:0] ret_idx,
  output logic                     issue_last,
  output logic                     ret_last
);

  localparam int CW = $clog2(BURST);
  localparam int RW = CW + 1;
  localparam logic [CW-1:0] ISSUE_MAX = CW'(BURST - 1);
  localparam logic [RW-1:0] RET_MAX   = RW'(BURST - 1);
  localparam logic [RW-1:0] RET_FULL  = RW'(BURST);

  // ret_cnt runs one past the last index so it can sit at BURST once the block is home
  logic [RW-1:0] ret_cnt;
  logic          ret_full;

  assign issue_last = (issue_cnt == ISSUE_MAX);
  assign ret_last   = (ret_cnt == RET_MAX);
  assign ret_full   = (ret_cnt == RET_FULL);
  assign ret_idx    = ret_cnt[CW-1:0];

  // Counters clear between transactions; the return counter never advances past a full block
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_cnt <= '0;
      ret_cnt   <= '0;
    end else if (clr) begin
      issue_cnt <= '0;
      ret_cnt   <= '0;
    end else begin
      if (issue_inc) begin
        issue_cnt <= issue_cnt + CW'(1);
      end
      if (ret_inc && !ret_full) begin
        ret_cnt <= ret_cnt + RW'(1);
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter sharing one pipelined data memory between D and I sides
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int BURST  = DEF_BURST,
  parameter int LAT    = DEF_LAT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     d_req,
  input  logic                     d_wr,
  input  logic [ADDR_W-1:0]        d_addr,
  input  logic [DATA_W-1:0]        d_wdata,
  output logic                     d_grant,
  output logic                     d_rvalid,
  output logic                     d_done,
  input  logic                     i_req,
  input  logic [ADDR_W-1:0]        i_addr,
  output logic                     i_grant,
  output logic                     i_rvalid,
  output logic                     i_done,
  output logic [DATA_W-1:0]        rdata,
  output logic [$clog2(BURST)-1:0] rword,
  output logic                     mem_en,
  output logic                     mem_wr,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     mem_rvalid
);

  localparam int CW = $clog2(BURST);
  localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'(2 * BURST - 1);
  localparam logic [31:0]       LAT_U    = 32'(LAT);

  state_t            state, state_nx;
  owner_t            owner, last_grant, winner;
  logic              any_req;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [ADDR_W-1:0] base;
  logic [CW-1:0]     issue_cnt, ret_idx;
  logic [31:0]       issue_ext;
  logic              issue_last, ret_last;
  logic              issue_inc, rd_active, ret_acc;

  assign any_req   = d_req | i_req;
  assign base      = addr_q & BLK_MASK;
  assign issue_ext = 32'(issue_cnt);

  // A return during RD_ISSUE is only genuine once the first address has had LAT cycles;
  // anything earlier is a leftover from a burst aborted by reset.
  assign ret_acc = rd_active & mem_rvalid & ((state == RD_DRAIN) | (issue_ext >= LAT_U));

  // Pick the winner among current requesters; on a tie the side that did not go last wins
  always_comb begin
    winner = OWN_D;
    if (d_req && i_req) begin
      winner = (last_grant == OWN_D) ? OWN_I : OWN_D;
    end else if (i_req) begin
      winner = OWN_I;
    end
  end

  // State register plus owner/address/data capture at the moment of grant
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= OWN_D;
      last_grant <= OWN_I;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && any_req) begin
        owner      <= winner;
        last_grant <= winner;
        addr_q     <= (winner == OWN_I) ? i_addr : d_addr;
        wdata_q    <= d_wdata;
      end
    end
  end

  // Next-state decode and memory-side strobes
  always_comb begin
    state_nx  = state;
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    issue_inc = 1'b0;
    rd_active = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          state_nx = (winner == OWN_D && d_wr) ? WR : RD_ISSUE;
        end
      end
      WR: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        state_nx  = DONE;
      end
      RD_ISSUE: begin
        mem_en    = 1'b1;
        mem_addr  = base | ADDR_W'({issue_cnt, 1'b0});
        issue_inc = 1'b1;
        rd_active = 1'b1;
        if (issue_last) begin
          state_nx = RD_DRAIN;
        end
      end
      RD_DRAIN: begin
        rd_active = 1'b1;
        if (ret_acc && ret_last) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign d_grant  = (state != IDLE) && (owner == OWN_D);
  assign i_grant  = (state != IDLE) && (owner == OWN_I);
  assign d_done   = (state == DONE) && (owner == OWN_D);
  assign i_done   = (state == DONE) && (owner == OWN_I);
  assign d_rvalid = ret_acc && (owner == OWN_D);
  assign i_rvalid = ret_acc && (owner == OWN_I);
  assign rdata    = ret_acc ? mem_rdata : '0;
  assign rword    = ret_acc ? ret_idx : '0;

  dmem_burst_ctr #(
    .BURST(BURST)
  ) u_ctr (
    .clk       (clk),
    .rst       (rst),
    .clr       (state == IDLE),
    .issue_inc (issue_inc),
    .ret_inc   (ret_acc),
    .issue_cnt (issue_cnt),
    .ret_idx   (ret_idx),
    .issue_last(issue_last),
    .ret_last  (ret_last)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int BURST  = 8;
  localparam int LAT    = 4;
  localparam int CW     = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              d_req, d_wr, i_req;
  logic [ADDR_W-1:0] d_addr, i_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_grant, d_rvalid, d_done;
  logic              i_grant, i_rvalid, i_done;
  logic [DATA_W-1:0] rdata;
  logic [CW-1:0]     rword;
  logic              mem_en, mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata  = '0;
  logic              mem_rvalid = 1'b0;

  logic              pv [LAT] = '{default: 1'b0};
  logic [DATA_W-1:0] pd [LAT] = '{default: '0};

  logic [6+DATA_W+CW+2+ADDR_W+DATA_W-1:0] all_out;

  int n_tests;
  int n_fail;

  assign all_out = {d_grant, d_rvalid, d_done, i_grant, i_rvalid, i_done,
                    rdata, rword, mem_en, mem_wr, mem_addr, mem_wdata};

  always #5 clk = ~clk;

  dmem_arbiter #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .BURST (BURST),
    .LAT   (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .d_req     (d_req),
    .d_wr      (d_wr),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_grant   (d_grant),
    .d_rvalid  (d_rvalid),
    .d_done    (d_done),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_grant   (i_grant),
    .i_rvalid  (i_rvalid),
    .i_done    (i_done),
    .rdata     (rdata),
    .rword     (rword),
    .mem_en    (mem_en),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_rvalid(mem_rvalid)
  );

  // Memory model: a read issued in cycle n returns in cycle n+LAT with 0xA000 + word index
  always @(negedge clk) begin
    mem_rvalid = pv[LAT-1];
    mem_rdata  = pd[LAT-1];
    for (int k = LAT - 1; k > 0; k--) begin
      pv[k] = pv[k-1];
      pd[k] = pd[k-1];
    end
    pv[0] = mem_en & ~mem_wr;
    pd[0] = 16'hA000 + {13'd0, mem_addr[3:1]};
  end

  task automatic tick();
    @(posedge clk);
    #7;
  endtask

  task automatic test_reset();
    rst    = 1'b0;
    d_req  = 1'b1;
    i_req  = 1'b1;
    d_wr   = 1'b0;
    d_addr = 16'h1236;
    i_addr = 16'h0106;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_tests++;
      if (all_out !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs cycle=%0d got=%h expected=0", c, all_out);
      end
    end
    rst = 1'b1;
    tick();
    n_tests++;
    if ({d_grant, i_grant} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_first_grant got d/i=%b expected 10", {d_grant, i_grant});
    end
    n_tests++;
    if (mem_en !== 1'b1 || mem_addr !== 16'h1230) begin
      n_fail++;
      $display("FAIL reset_first_issue got en=%b addr=%h expected en=1 addr=1230", mem_en, mem_addr);
    end
    rst   = 1'b0;
    d_req = 1'b0;
    i_req = 1'b0;
    repeat (LAT + 3) tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_d_read();
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed;
    logic [CW-1:0]     ew;
    logic              e_en, e_rv, e_dn, e_gr;
    d_req  = 1'b1;
    d_wr   = 1'b0;
    d_addr = 16'h1236;
    for (int c = 1; c <= 15; c++) begin
      tick();
      e_en = (c >= 1 && c <= 8);
      e_rv = (c >= 5 && c <= 12);
      e_dn = (c == 13);
      e_gr = (c <= 13);
      ea   = 16'h1230 + ADDR_W'(2 * (c - 1));
      ed   = 16'hA000 + DATA_W'(c - 5);
      ew   = CW'(c - 5);
      n_tests++;
      if (mem_en !== e_en || (e_en && (mem_wr !== 1'b0 || mem_addr !== ea))) begin
        n_fail++;
        $display("FAIL d_read_issue c=%0d got en=%b wr=%b addr=%h expected en=%b wr=0 addr=%h",
                 c, mem_en, mem_wr, mem_addr, e_en, ea);
      end
      n_tests++;
      if (d_rvalid !== e_rv || (e_rv && (rword !== ew || rdata !== ed))) begin
        n_fail++;
        $display("FAIL d_read_return c=%0d got rv=%b word=%0d data=%h expected rv=%b word=%0d data=%h",
                 c, d_rvalid, rword, rdata, e_rv, ew, ed);
      end
      n_tests++;
      if ({d_grant, d_done} !== {e_gr, e_dn}) begin
        n_fail++;
        $display("FAIL d_read_grant_done c=%0d got %b expected %b", c, {d_grant, d_done}, {e_gr, e_dn});
      end
      n_tests++;
      if ({i_grant, i_rvalid, i_done} !== 3'b000) begin
        n_fail++;
        $display("FAIL d_read_i_quiet c=%0d got %b expected 000", c, {i_grant, i_rvalid, i_done});
      end
      if (c == 1) d_addr = 16'hFFFE;
      if (c == 13) d_req = 1'b0;
    end
  endtask

  task automatic test_d_write();
    d_req   = 1'b1;
    d_wr    = 1'b1;
    d_addr  = 16'h0040;
    d_wdata = 16'hBEEF;
    tick();
    d_addr  = 16'h0000;
    d_wdata = 16'h0000;
    #1;
    n_tests++;
    if ({mem_en, mem_wr} !== 2'b11 || mem_addr !== 16'h0040 || mem_wdata !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL d_write_strobe got en/wr=%b addr=%h wdata=%h expected 11 0040 beef",
               {mem_en, mem_wr}, mem_addr, mem_wdata);
    end
    n_tests++;
    if ({d_grant, d_done, d_rvalid} !== 3'b100) begin
      n_fail++;
      $display("FAIL d_write_c1_flags got %b expected 100", {d_grant, d_done, d_rvalid});
    end
    tick();
    n_tests++;
    if ({mem_en, d_grant, d_done} !== 3'b011) begin
      n_fail++;
      $display("FAIL d_write_done got en/grant/done=%b expected 011", {mem_en, d_grant, d_done});
    end
    d_req = 1'b0;
    d_wr  = 1'b0;
    tick();
    n_tests++;
    if ({d_grant, d_done, mem_en} !== 3'b000) begin
      n_fail++;
      $display("FAIL d_write_idle got %b expected 000", {d_grant, d_done, mem_en});
    end
  endtask

  task automatic test_tie();
    logic [ADDR_W-1:0] base;
    logic              own_i;
    int                n_iss, n_ret;
    logic              seen;
    rst    = 1'b0;
    d_req  = 1'b1;
    i_req  = 1'b1;
    d_wr   = 1'b0;
    d_addr = 16'h1236;
    i_addr = 16'h0106;
    tick();
    tick();
    rst = 1'b1;
    for (int g = 0; g < 3; g++) begin
      own_i = (g == 1);
      base  = own_i ? 16'h0100 : 16'h1230;
      n_iss = 0;
      n_ret = 0;
      seen  = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
        tick();
        if (mem_en === 1'b1) begin
          n_tests++;
          if (mem_addr !== base + ADDR_W'(2 * n_iss)) begin
            n_fail++;
            $display("FAIL tie_addr g=%0d n=%0d got %h expected %h", g, n_iss, mem_addr, base + ADDR_W'(2 * n_iss));
          end
          n_iss++;
        end
        if ((d_rvalid | i_rvalid) === 1'b1) begin
          n_tests++;
          if ({d_rvalid, i_rvalid} !== {~own_i, own_i} || rword !== CW'(n_ret) ||
              rdata !== 16'hA000 + DATA_W'(n_ret)) begin
            n_fail++;
            $display("FAIL tie_return g=%0d n=%0d got d/i=%b word=%0d data=%h expected d/i=%b word=%0d data=%h",
                     g, n_ret, {d_rvalid, i_rvalid}, rword, rdata, {~own_i, own_i}, n_ret,
                     16'hA000 + DATA_W'(n_ret));
          end
          n_ret++;
        end
        if ((d_done | i_done) === 1'b1) begin
          seen = 1'b1;
          n_tests++;
          if ({d_done, i_done, d_grant, i_grant} !== {~own_i, own_i, ~own_i, own_i}) begin
            n_fail++;
            $display("FAIL tie_owner g=%0d got done d/i=%b grant d/i=%b expected owner_i=%b",
                     g, {d_done, i_done}, {d_grant, i_grant}, own_i);
          end
        end
      end
      n_tests++;
      if (!seen || n_iss != BURST || n_ret != BURST) begin
        n_fail++;
        $display("FAIL tie_burst g=%0d got done=%b issues=%0d returns=%0d expected 1 %0d %0d",
                 g, seen, n_iss, n_ret, BURST, BURST);
      end
      if (own_i) i_req = 1'b0;
      else d_req = 1'b0;
      tick();
      d_req = 1'b1;
      i_req = 1'b1;
    end
    d_req = 1'b0;
    i_req = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset_mid_burst();
    d_req  = 1'b1;
    d_wr   = 1'b0;
    d_addr = 16'h1236;
    for (int c = 1; c <= 4; c++) tick();
    n_tests++;
    if (mem_en !== 1'b1 || mem_addr !== 16'h1236) begin
      n_fail++;
      $display("FAIL mid_reset_issue3 got en=%b addr=%h expected en=1 addr=1236", mem_en, mem_addr);
    end
    rst   = 1'b0;
    d_req = 1'b0;
    #1;
    n_tests++;
    if (all_out !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_async got=%h expected=0", all_out);
    end
    tick();
    n_tests++;
    if (all_out !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_held got=%h expected=0", all_out);
    end
    rst = 1'b1;
    for (int c = 6; c <= 12; c++) begin
      tick();
      n_tests++;
      if ({d_grant, d_rvalid, d_done, i_grant, i_rvalid, i_done} !== 6'b0) begin
        n_fail++;
        $display("FAIL mid_reset_stray c=%0d mem_rvalid=%b got %b expected 000000",
                 c, mem_rvalid, {d_grant, d_rvalid, d_done, i_grant, i_rvalid, i_done});
      end
    end
  endtask

  task automatic test_late_request();
    logic seen;
    d_req  = 1'b1;
    d_wr   = 1'b0;
    d_addr = 16'h1236;
    i_addr = 16'h0106;
    for (int c = 1; c <= 15; c++) begin
      tick();
      if (c == 13) begin
        n_tests++;
        if (d_done !== 1'b1) begin
          n_fail++;
          $display("FAIL late_d_done c=13 got %b expected 1", d_done);
        end
      end
      if (c >= 10 && c <= 14) begin
        n_tests++;
        if (i_grant !== 1'b0) begin
          n_fail++;
          $display("FAIL late_i_wait c=%0d got i_grant=%b expected 0", c, i_grant);
        end
      end
      if (c == 15) begin
        n_tests++;
        if ({d_grant, i_grant} !== 2'b01) begin
          n_fail++;
          $display("FAIL late_i_grant c=15 got d/i=%b expected 01", {d_grant, i_grant});
        end
      end
      if (c == 10) i_req = 1'b1;
      if (c == 13) d_req = 1'b0;
    end
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      if (i_done === 1'b1) seen = 1'b1;
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL late_i_done got no i_done within 20 cycles expected one");
    end
    i_req = 1'b0;
    tick();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    d_req   = 1'b0;
    d_wr    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    i_req   = 1'b0;
    i_addr  = '0;
    #2;
    rst = 1'b0;
    test_reset();
    test_d_read();
    test_d_write();
    test_tie();
    test_reset_mid_burst();
    test_late_request();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
